sd_rx_fifo_packer: RTL
======================

# sd_rx_fifo_packer

Receive-path data buffer for the SD controller, the counterpart of the transmit FIFO. It packs the 4-bit nibble stream from the SD data-line deserializer into 32-bit words, MSB nibble first, and queues them in a single-clock FIFO. The host/bus side drains the FIFO. The block reports fill level, almost-full (used to stall the SD clock) and a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in words; power of two.
- ADR_SIZE, 5: pointer width, log2(DEPTH)+1; the MSB is the wrap bit.
- AFULL, 12: fill level at or above which afull asserts; must be ≤ DEPTH.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  4  nibble from the SD data lines, DAT3 in bit 3.
- din_valid  in  1  din is sampled on this clock edge.
- blk_end  in  1  one-cycle pulse at end of a data block; flushes a partial word.
- clr  in  1  synchronous clear of the FIFO, packer and overflow flag.
- q  out  32  head word; first-word-fall-through.
- rd  in  1  pop the head word.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- fill  out  ADR_SIZE  current word count, 0..DEPTH.
- afull  out  1  fill ≥ AFULL.
- ovf  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
**Packer**
- Holds a 32-bit shift register sreg and a 3-bit nibble counter nib_cnt.
- On din_valid: sreg <= {sreg[27:0], din} and nib_cnt increments. The first nibble of a word ends in q[31:28].
- When din_valid arrives with nib_cnt==7, the completed word {sreg[27:0], din} is pushed and nib_cnt wraps to 0.

**blk_end flush**
- With din_valid=0 and nib_cnt=n≠0, push sreg << 4*(8-n): left-justified, low nibbles zero. nib_cnt becomes 0.
- With din_valid=1 in the same cycle, the nibble is absorbed first.
  - If that completes the word, exactly one word is pushed.
  - Otherwise the padded partial word, including the new nibble, is pushed.
- With nib_cnt=0 and no din_valid, blk_end has no effect.

**Push**
- A push is accepted only when full=0. A simultaneous rd does not free a slot for the same cycle's push.
- A push while full=1 drops the word and sets ovf=1.

**FIFO**
- Wrap-bit pointers wptr and rptr, each ADR_SIZE bits. RAM is indexed by the low ADR_SIZE-1 bits.
- empty = (wptr == rptr).
- full = (low bits equal) and (wrap bits differ).
- fill = wptr - rptr, computed modulo 2^ADR_SIZE.
- rd with empty=0 advances rptr. rd with empty=1 is ignored.
- A simultaneous accepted push and pop leaves fill unchanged.

**Clear and reset**
- clr takes precedence over din_valid, blk_end and rd in the same cycle. It zeroes wptr, rptr, nib_cnt, sreg and ovf.
- rst_n=0 immediately, without waiting for a clock edge, forces the same state.
- The RAM contents are not reset.

## Timing
- Reset or clr values: empty=1, full=0, fill=0, afull=0, ovf=0. q is don't-care while empty=1.
- Latency: the word is written on the edge that samples the 8th nibble, or on the blk_end edge. On the following cycle empty=0, fill is incremented and q shows the word if the FIFO was empty.
- rd is sampled on the rising edge. On the next cycle q shows the next word and fill is decremented.
- full, empty, fill and afull are combinational from the pointers, so they update in the cycle after the pointer change.
- ovf sets on the edge of the dropped push and holds until clr or reset.
- Sustained throughput: one word per 8 din_valid cycles in, one word per cycle out.
- Releasing rst_n mid-stream discards the partial word. Packing restarts at nibble 0.

## Test plan
1. After reset, nibbles 1,2,3,4,5,6,7,8 on consecutive cycles -> the cycle after the 8th: q=32'h12345678, fill=1, empty=0. rd -> empty=1, fill=0.
2. Nibbles A,B,C then blk_end -> q=32'hABC00000. Next, blk_end in the same cycle as the 8th nibble of 8'h9 nibbles -> exactly one word 32'h99999999, fill=2.
3. Push 16 words 0..15 with no rd -> afull rises when fill reaches 12, full=1 at 16. The 17th word is dropped: ovf=1, fill stays 16. Reading 16 times returns 0..15 in order, then empty=1; ovf stays 1 until clr.
4. At fill=5, an accepted push and an rd in the same cycle -> fill stays 5. Stream 40 words with rd whenever empty=0 -> all 40 read in order, pointers wrap twice, ovf=0.
5. rd while empty -> pointers and fill unchanged. clr when nib_cnt=5 and fill=3 -> fill=0, empty=1; the next 8 nibbles 8'hF form a clean 32'hFFFFFFFF.
6. Assert rst_n=0 mid-cycle with fill=7 -> empty=1, fill=0, ovf=0 before the next clk edge. After release, a normal 8-nibble word is accepted.

Source files
------------

// File: rtl/sd_rx_fifo_packer_if.sv
// SD receive FIFO port bundle: nibble input side and word drain side.
// The slave modport is the packer; the master modport is the SD deserializer plus host.
interface sd_rx_fifo_packer_if #(
   parameter int ADR_SIZE = 5
);
   logic [3:0]          din;
   logic                din_valid;
   logic                blk_end;
   logic                clr;
   logic [31:0]         q;
   logic                rd;
   logic                full;
   logic                empty;
   logic [ADR_SIZE-1:0] fill;
   logic                afull;
   logic                ovf;

   modport master (
      output din, din_valid, blk_end, clr, rd,
      input  q, full, empty, fill, afull, ovf
   );

   modport slave (
      input  din, din_valid, blk_end, clr, rd,
      output q, full, empty, fill, afull, ovf
   );
endinterface

// File: rtl/sd_rx_fifo_packer.sv
// SD receive buffer: packs 4-bit nibbles MSB-first into 32-bit words and queues
// them in a first-word-fall-through FIFO with fill, almost-full and sticky overflow.
module sd_rx_fifo_packer #(
   parameter int DEPTH    = 16,
   parameter int ADR_SIZE = 5,
   parameter int AFULL    = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   sd_rx_fifo_packer_if.slave bus
);
   localparam int AW = ADR_SIZE - 1;
   localparam logic [ADR_SIZE-1:0] AFULL_L = ADR_SIZE'(AFULL);

   logic [31:0]         sreg, sreg_nxt, push_word;
   logic [2:0]          nib_cnt, cnt_nxt;
   logic                push, wr_en;
   logic [ADR_SIZE-1:0] wptr, rptr, fill;
   logic                full, empty, ovf;
   logic [31:0]         mem [DEPTH];

   // Absorb this cycle's nibble first, then decide between a full word and a padded flush.
   always_comb begin
      sreg_nxt  = bus.din_valid ? {sreg[27:0], bus.din} : sreg;
      cnt_nxt   = nib_cnt + 3'(bus.din_valid);
      push      = 1'b0;
      push_word = sreg_nxt;
      if (bus.din_valid && nib_cnt == 3'd7) begin
         push = 1'b1;
      end else if (bus.blk_end && cnt_nxt != 3'd0) begin
         push      = 1'b1;
         // (0 - n) mod 8 == 8 - n for n in 1..7; times 4 gives the pad shift
         push_word = sreg_nxt << {3'd0 - cnt_nxt, 2'b00};
      end
   end

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign fill  = wptr - rptr;
   assign wr_en = push && !full && !bus.clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg    <= '0;
         nib_cnt <= '0;
         wptr    <= '0;
         rptr    <= '0;
         ovf     <= 1'b0;
      end else if (bus.clr) begin
         sreg    <= '0;
         nib_cnt <= '0;
         wptr    <= '0;
         rptr    <= '0;
         ovf     <= 1'b0;
      end else begin
         sreg    <= sreg_nxt;
         nib_cnt <= push ? 3'd0 : cnt_nxt;
         if (push && !full) wptr <= wptr + ADR_SIZE'(1);
         if (push && full)  ovf  <= 1'b1;
         if (bus.rd && !empty) rptr <= rptr + ADR_SIZE'(1);
      end
   end

   // Storage is deliberately not reset; empty masks stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= push_word;
   end

   assign bus.q     = mem[rptr[AW-1:0]];
   assign bus.full  = full;
   assign bus.empty = empty;
   assign bus.fill  = fill;
   assign bus.afull = (fill >= AFULL_L);
   assign bus.ovf   = ovf;
endmodule
